// File: rtl/ms_pkg.sv
// Shared definitions for the ms valid/ready family: default sizes, a beat
// record for chained benches and the pointer wrap helper.
package ms_pkg;

    localparam int unsigned MS_DATA_W = 8;
    localparam int unsigned MS_DEPTH  = 2;

    typedef struct packed {
        logic [MS_DATA_W-1:0] data;
        logic                 valid;
    } ms_beat_t;

    // Step a pointer by one, returning to zero after depth-1. An explicit
    // compare keeps non-power-of-two depths correct.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ms_proto_chk.sv
// Sticky upstream protocol checker for an ms valid/ready interface. Once a
// beat is offered while ready is low, it must stay valid and unchanged until
// it is accepted; any withdrawal or change latches err_o until reset.
module ms_proto_chk #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              err_o
);

    logic              armed_q;
    logic              err_q;
    logic [DATA_W-1:0] cap_q;

    // Arm on a stalled offer, flag a broken hold on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= valid_i & ~ready_i;
            if (armed_q && (!valid_i || (data_i != cap_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    // Remember the stalled payload so the next edge can compare against it.
    always_ff @(posedge clk) begin
        if (valid_i && !ready_i) begin
            cap_q <= data_i;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/ms_elastic_buf.sv
// Elastic valid/ready buffer of DEPTH entries. Both handshake flags are
// registered from the next occupancy, so nothing downstream reaches the
// upstream ready combinationally. The head entry is held in its own register
// so d2u_data_o keeps its last value while the buffer is empty.
module ms_elastic_buf
    import ms_pkg::*;
#(
    parameter  int unsigned DATA_W = MS_DATA_W,
    parameter  int unsigned DEPTH  = MS_DEPTH,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] u2d_data_i,
    input  logic              u2d_valid_i,
    output logic              u2d_ready_o,
    output logic [DATA_W-1:0] d2u_data_o,
    output logic              d2u_valid_o,
    input  logic              d2u_ready_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              err_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_after_pop;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              push;
    logic              pop;

    // Next-state for pointers, occupancy, head register and handshake flags.
    always_comb begin
        push            = u2d_valid_i & rdy_q;
        pop             = vld_q & d2u_ready_i;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        head_d          = head_q;
        count_after_pop = count_q - CNT_W'(pop);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
            end
            count_d = count_after_pop + CNT_W'(push);

            // The new head is either an entry already stored, or the beat
            // arriving now when nothing else remains behind the popped one.
            if (count_after_pop != '0) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push) begin
                head_d = u2d_data_i;
            end
        end

        rdy_d = (count_d < CNT_W'(DEPTH));
        vld_d = (count_d != '0);
    end

    // Control state and the visible head; all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            head_q   <= head_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= u2d_data_i;
        end
    end

    ms_proto_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (u2d_valid_i),
        .ready_i (rdy_q),
        .data_i  (u2d_data_i),
        .err_o   (err_o)
    );

    assign u2d_ready_o = rdy_q;
    assign d2u_valid_o = vld_q;
    assign d2u_data_o  = head_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_ms_elastic_buf.sv
// Directed bench for ms_elastic_buf: one instance at DEPTH=2 (a_*) and one
// at DEPTH=3 (b_*), sharing clock and reset.
module tb_ms_elastic_buf;
    import ms_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic [7:0] a_din, a_dout;
    logic       a_vin, a_rdy, a_vout, a_dr, a_flush, a_err;
    logic [1:0] a_cnt;

    logic [7:0] b_din, b_dout;
    logic       b_vin, b_rdy, b_vout, b_dr, b_flush, b_err;
    logic [1:0] b_cnt;

    int total;
    int bad;

    ms_elastic_buf #(.DATA_W(8), .DEPTH(2)) u_a (
        .clk (clk), .rst_n (rst_n),
        .u2d_data_i (a_din), .u2d_valid_i (a_vin), .u2d_ready_o (a_rdy),
        .d2u_data_o (a_dout), .d2u_valid_o (a_vout), .d2u_ready_i (a_dr),
        .flush_i (a_flush), .count_o (a_cnt), .err_o (a_err)
    );

    ms_elastic_buf #(.DATA_W(8), .DEPTH(3)) u_b (
        .clk (clk), .rst_n (rst_n),
        .u2d_data_i (b_din), .u2d_valid_i (b_vin), .u2d_ready_o (b_rdy),
        .d2u_data_o (b_dout), .d2u_valid_o (b_vout), .d2u_ready_i (b_dr),
        .flush_i (b_flush), .count_o (b_cnt), .err_o (b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_din = '0; a_vin = 1'b0; a_dr = 1'b0; a_flush = 1'b0;
        b_din = '0; b_vin = 1'b0; b_dr = 1'b0; b_flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        total++;
        if ({a_vout, a_rdy, a_cnt, a_err, a_dout} !== 13'd0) begin
            bad++;
            $display("FAIL reset_a got v=%0b r=%0b c=%0d e=%0b d=%0d exp all 0", a_vout, a_rdy, a_cnt, a_err, a_dout);
        end
        total++;
        if ({b_vout, b_rdy, b_cnt, b_err, b_dout} !== 13'd0) begin
            bad++;
            $display("FAIL reset_b got v=%0b r=%0b c=%0d e=%0b d=%0d exp all 0", b_vout, b_rdy, b_cnt, b_err, b_dout);
        end
        step();
        step();
        rst_n = 1'b1;
        #2;
        total++;
        if (a_rdy !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%0b exp=0", a_rdy);
        end
        step();
        total++;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1 || a_vout !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_edge got a=%0b b=%0b v=%0b exp a=1 b=1 v=0", a_rdy, b_rdy, a_vout);
        end
    endtask

    task automatic test_stream();
        a_dr = 1'b1;
        a_vin = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_din = 8'(i);
            step();
            total++;
            if (a_vout !== 1'b1 || a_dout !== 8'(i)) begin
                bad++;
                $display("FAIL stream_out[%0d] got v=%0b d=%0d exp v=1 d=%0d", i, a_vout, a_dout, i);
            end
            total++;
            if (a_cnt !== 2'd1 || a_rdy !== 1'b1) begin
                bad++;
                $display("FAIL stream_flags[%0d] got c=%0d r=%0b exp c=1 r=1", i, a_cnt, a_rdy);
            end
        end
        a_vin = 1'b0;
        step();
        total++;
        if (a_vout !== 1'b0 || a_cnt !== 2'd0 || a_dout !== 8'd15) begin
            bad++;
            $display("FAIL stream_drain got v=%0b c=%0d d=%0d exp v=0 c=0 d=15", a_vout, a_cnt, a_dout);
        end
        a_dr = 1'b0;
    endtask

    task automatic test_backpressure();
        a_dr = 1'b0;
        a_vin = 1'b1;
        a_din = 8'd16;
        step();
        a_din = 8'd17;
        step();
        total++;
        if (a_cnt !== 2'd2 || a_rdy !== 1'b0 || a_dout !== 8'd16) begin
            bad++;
            $display("FAIL bp_full got c=%0d r=%0b d=%0d exp c=2 r=0 d=16", a_cnt, a_rdy, a_dout);
        end
        a_din = 8'd18;
        step();
        total++;
        if (a_cnt !== 2'd2 || a_rdy !== 1'b0 || a_dout !== 8'd16 || a_vout !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold got c=%0d r=%0b d=%0d v=%0b exp c=2 r=0 d=16 v=1", a_cnt, a_rdy, a_dout, a_vout);
        end
        a_dr = 1'b1;
        step();
        total++;
        if (a_cnt !== 2'd1 || a_rdy !== 1'b1 || a_dout !== 8'd17) begin
            bad++;
            $display("FAIL bp_pop1 got c=%0d r=%0b d=%0d exp c=1 r=1 d=17", a_cnt, a_rdy, a_dout);
        end
        step();
        total++;
        if (a_cnt !== 2'd1 || a_dout !== 8'd18 || a_vout !== 1'b1) begin
            bad++;
            $display("FAIL bp_pop2 got c=%0d d=%0d v=%0b exp c=1 d=18 v=1", a_cnt, a_dout, a_vout);
        end
        a_vin = 1'b0;
        step();
        total++;
        if (a_cnt !== 2'd0 || a_vout !== 1'b0 || a_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got c=%0d v=%0b e=%0b exp c=0 v=0 e=0", a_cnt, a_vout, a_err);
        end
        a_dr = 1'b0;
    endtask

    task automatic test_full_pop();
        b_dr = 1'b0;
        b_vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_din = 8'(60 + i);
            step();
        end
        total++;
        if (b_cnt !== 2'd3 || b_rdy !== 1'b0 || b_dout !== 8'd60) begin
            bad++;
            $display("FAIL full_fill got c=%0d r=%0b d=%0d exp c=3 r=0 d=60", b_cnt, b_rdy, b_dout);
        end
        b_din = 8'd63;
        b_dr = 1'b1;
        step();
        total++;
        if (b_cnt !== 2'd2 || b_rdy !== 1'b1 || b_dout !== 8'd61) begin
            bad++;
            $display("FAIL full_pop got c=%0d r=%0b d=%0d exp c=2 r=1 d=61", b_cnt, b_rdy, b_dout);
        end
        step();
        total++;
        if (b_cnt !== 2'd2 || b_dout !== 8'd62) begin
            bad++;
            $display("FAIL full_steady1 got c=%0d d=%0d exp c=2 d=62", b_cnt, b_dout);
        end
        b_din = 8'd64;
        step();
        total++;
        if (b_cnt !== 2'd2 || b_dout !== 8'd63) begin
            bad++;
            $display("FAIL full_steady2 got c=%0d d=%0d exp c=2 d=63", b_cnt, b_dout);
        end
        b_vin = 1'b0;
        step();
        total++;
        if (b_cnt !== 2'd1 || b_dout !== 8'd64) begin
            bad++;
            $display("FAIL full_tail got c=%0d d=%0d exp c=1 d=64", b_cnt, b_dout);
        end
        step();
        total++;
        if (b_cnt !== 2'd0 || b_vout !== 1'b0 || b_err !== 1'b0) begin
            bad++;
            $display("FAIL full_drain got c=%0d v=%0b e=%0b exp c=0 v=0 e=0", b_cnt, b_vout, b_err);
        end
        b_dr = 1'b0;
    endtask

    task automatic test_wrap();
        int       exp_out;
        int       nxt;
        int       cnt;
        int       dummy;
        ms_beat_t pre;
        logic     pre_rdy;
        logic     pre_dr;
        logic     pre_vin;
        exp_out = 20;
        nxt     = 20;
        cnt     = 0;
        dummy   = $urandom(32'd2024);
        for (int cyc = 0; cyc < 400 && exp_out < 30; cyc++) begin
            b_dr  = 1'($urandom_range(0, 1));
            b_vin = (nxt < 30);
            b_din = 8'(nxt);
            pre.data  = b_dout;
            pre.valid = b_vout;
            pre_rdy   = b_rdy;
            pre_dr    = b_dr;
            pre_vin   = b_vin;
            step();
            if (pre.valid && pre_dr) begin
                total++;
                if (pre.data !== 8'(exp_out)) begin
                    bad++;
                    $display("FAIL wrap_order got=%0d exp=%0d", pre.data, exp_out);
                end
                exp_out++;
            end
            if (pre.valid && !pre_dr) begin
                total++;
                if (b_vout !== 1'b1 || b_dout !== pre.data) begin
                    bad++;
                    $display("FAIL wrap_stable got v=%0b d=%0d exp v=1 d=%0d", b_vout, b_dout, pre.data);
                end
            end
            if (pre_vin && pre_rdy) nxt++;
            cnt = cnt + ((pre_vin && pre_rdy) ? 1 : 0) - ((pre.valid && pre_dr) ? 1 : 0);
            total++;
            if (b_cnt !== 2'(cnt)) begin
                bad++;
                $display("FAIL wrap_count got=%0d exp=%0d", b_cnt, cnt);
            end
        end
        total++;
        if (exp_out != 30) begin
            bad++;
            $display("FAIL wrap_done got=%0d beats exp=10", exp_out - 20);
        end
        b_vin = 1'b0;
        b_dr  = 1'b0;
        total++;
        if (b_err !== 1'b0 || b_vout !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end got e=%0b v=%0b exp e=0 v=0", b_err, b_vout);
        end
    endtask

    task automatic test_flush();
        b_dr = 1'b0;
        b_vin = 1'b1;
        b_din = 8'd30;
        step();
        b_din = 8'd31;
        step();
        total++;
        if (b_cnt !== 2'd2 || b_rdy !== 1'b1) begin
            bad++;
            $display("FAIL flush_setup got c=%0d r=%0b exp c=2 r=1", b_cnt, b_rdy);
        end
        b_flush = 1'b1;
        b_din = 8'd40;
        b_dr = 1'b1;
        step();
        total++;
        if (b_cnt !== 2'd0 || b_vout !== 1'b0 || b_rdy !== 1'b1 || b_dout !== 8'd30) begin
            bad++;
            $display("FAIL flush_clear got c=%0d v=%0b r=%0b d=%0d exp c=0 v=0 r=1 d=30", b_cnt, b_vout, b_rdy, b_dout);
        end
        b_flush = 1'b0;
        b_vin = 1'b0;
        b_dr = 1'b0;
        step();
        total++;
        if (b_cnt !== 2'd0 || b_vout !== 1'b0) begin
            bad++;
            $display("FAIL flush_nostore got c=%0d v=%0b exp c=0 v=0", b_cnt, b_vout);
        end
        b_vin = 1'b1;
        b_din = 8'd41;
        step();
        total++;
        if (b_vout !== 1'b1 || b_dout !== 8'd41 || b_cnt !== 2'd1) begin
            bad++;
            $display("FAIL flush_after got v=%0b d=%0d c=%0d exp v=1 d=41 c=1", b_vout, b_dout, b_cnt);
        end
        b_vin = 1'b0;
        b_dr = 1'b1;
        step();
        total++;
        if (b_cnt !== 2'd0 || b_err !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain got c=%0d e=%0b exp c=0 e=0", b_cnt, b_err);
        end
        b_dr = 1'b0;
    endtask

    task automatic test_proto_reset();
        a_dr = 1'b0;
        a_vin = 1'b1;
        a_din = 8'd48;
        step();
        a_din = 8'd49;
        step();
        a_din = 8'd50;
        step();
        total++;
        if (a_err !== 1'b0 || a_rdy !== 1'b0) begin
            bad++;
            $display("FAIL proto_armed got e=%0b r=%0b exp e=0 r=0", a_err, a_rdy);
        end
        a_din = 8'd51;
        step();
        total++;
        if (a_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_err got=%0b exp=1", a_err);
        end
        a_vin = 1'b0;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        step();
        total++;
        if (a_err !== 1'b1 || a_cnt !== 2'd0) begin
            bad++;
            $display("FAIL proto_sticky got e=%0b c=%0d exp e=1 c=0", a_err, a_cnt);
        end
        a_vin = 1'b1;
        a_din = 8'd52;
        step();
        total++;
        if (a_vout !== 1'b1 || a_cnt !== 2'd1 || a_dout !== 8'd52) begin
            bad++;
            $display("FAIL proto_refill got v=%0b c=%0d d=%0d exp v=1 c=1 d=52", a_vout, a_cnt, a_dout);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_vout, a_rdy, a_cnt, a_err, a_dout} !== 13'd0) begin
            bad++;
            $display("FAIL midreset_a got v=%0b r=%0b c=%0d e=%0b d=%0d exp all 0", a_vout, a_rdy, a_cnt, a_err, a_dout);
        end
        total++;
        if ({b_vout, b_rdy, b_cnt, b_err, b_dout} !== 13'd0) begin
            bad++;
            $display("FAIL midreset_b got v=%0b r=%0b c=%0d e=%0b d=%0d exp all 0", b_vout, b_rdy, b_cnt, b_err, b_dout);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (a_rdy !== 1'b1 || a_vout !== 1'b0 || a_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release got r=%0b v=%0b e=%0b exp r=1 v=0 e=0", a_rdy, a_vout, a_err);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_flush();
        test_proto_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ms_elastic_buf.md
Name: ms_elastic_buf

Overview:
Parametrised successor of the single-stage ms valid/ready node. It is an elastic buffer of configurable data width and depth, and it sustains full throughput. u2d_ready_o is registered, so there is no combinational path from d2u_ready_i to u2d_ready_o. The block also adds occupancy reporting, a synchronous flush and a sticky upstream-protocol checker. It drops into any ms chain, e.g. tb -> ms_elastic_buf -> ms_elastic_buf -> tb.

Parameters:
DATA_W, 8, payload width in bits.
DEPTH, 2, number of storage entries; legal range is DEPTH >= 2, and DEPTH need not be a power of two.
CNT_W, $clog2(DEPTH+1), localparam; width of the occupancy count.
PTR_W, $clog2(DEPTH), localparam (minimum 1); width of the read/write pointers.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
u2d_data_i  in  DATA_W  upstream payload.
u2d_valid_i  in  1  upstream valid.
u2d_ready_o  out  1  ready to upstream; registered.
d2u_data_o  out  DATA_W  downstream payload; the head entry.
d2u_valid_o  out  1  downstream valid; registered.
d2u_ready_i  in  1  downstream ready.
flush_i  in  1  synchronous discard of all stored entries.
count_o  out  CNT_W  current occupancy, 0..DEPTH.
err_o  out  1  sticky upstream protocol violation flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, wr_ptr = rd_ptr = 0.
  - d2u_valid_o = 0, u2d_ready_o = 0, err_o = 0, count_o = 0.
  - d2u_data_o = 0; storage contents are don't-care.
- The first rising edge after rst_n deasserts sets u2d_ready_o = 1.
- Handshakes:
  - push = u2d_valid_i & u2d_ready_o.
  - pop = d2u_valid_o & d2u_ready_i.
  - Both are evaluated at the rising edge.
- Registered flags:
  - u2d_ready_o_next = (count_next < DEPTH).
  - d2u_valid_o_next = (count_next != 0).
  - Both are registered; neither output depends combinationally on any input.
- Latency: a beat pushed at edge N appears on d2u_data_o with d2u_valid_o = 1 after edge N, provided the buffer was empty.
- Throughput: with valid and ready held high continuously, count stays at 1 and one beat passes per cycle.
- Ordering: strict FIFO.
- Output stability: while d2u_valid_o = 1 and d2u_ready_i = 0, d2u_data_o and d2u_valid_o hold stable.
- Simultaneous push and pop: count is unchanged, both pointers advance, and the output takes the next entry.
- Full (count = DEPTH): u2d_ready_o = 0, so no push is possible. A pop at this edge raises u2d_ready_o in the next cycle; there is no same-cycle re-fill.
- Empty: d2u_valid_o = 0 and d2u_data_o holds its last value. A push at this edge makes valid = 1 in the next cycle; there is no bypass path.
- Pointer wrap: pointers step from DEPTH-1 to 0 by explicit compare, not by modulo 2^PTR_W.
- Flush (flush_i = 1 at an edge):
  - count -> 0, pointers -> 0, d2u_valid_o -> 0, u2d_ready_o -> 1.
  - A coincident push or pop is ignored; flush has priority.
  - err_o is unaffected.
- Protocol checker:
  - Arms when u2d_valid_i = 1 and u2d_ready_o = 0 at an edge; it captures u2d_data_i.
  - While armed, at the next edge, err_o sets if u2d_valid_i = 0, or if u2d_data_i differs from the captured value.
  - It disarms when the handshake completes.
  - err_o is cleared only by reset.
- Reset mid-operation: all stored data is lost immediately (asynchronously) and outputs return to reset values. No partial beat is emitted.

Decomposition:
- Package ms_pkg holds:
  - The default DATA_W and DEPTH constants.
  - A typedef struct {data, valid} ms_beat_t for chained benches.
  - A function next_ptr(ptr, depth) implementing the wrap rule.
- Sub-module ms_proto_chk (clk, rst_n, valid, ready, data -> err) holds the sticky checker logic, so it can be reused on any ms interface.
- The top level holds the storage array, pointers, count and registered flags.

Test Plan:
- Streaming: after reset, push 0..15 back-to-back with d2u_ready_i = 1.
  - Required: out 0..15, one per cycle, first beat 1 cycle after its push.
  - Required: count_o stays 1 and u2d_ready_o is never low.
- Backpressure (DEPTH = 2): hold d2u_ready_i = 0 and offer 16, 17, 18.
  - Required: 16 and 17 are accepted, count_o = 2, u2d_ready_o = 0, 18 is held.
  - Then raise ready: out 16, 17, 18 in order with no loss or duplication.
- Full with simultaneous pop (DEPTH = 3): fill to 3, then pop with u2d_valid_i = 1.
  - Required: u2d_ready_o rises 1 cycle after the pop.
  - Required: count sequence 3 -> 2 -> 2 under steady push/pop.
- Wrap (DEPTH = 3): push 20..29 with random ready (seeded).
  - Required: out 20..29 in order.
  - Required: pointers wrap 2 -> 0 and the d2u_data_o stability rule is never violated.
- Flush: with 2 entries stored, assert flush_i together with a push of 40.
  - Required: count_o = 0 and d2u_valid_o = 0 next cycle; 40 is not stored.
  - Then push 41: out 41.
- Protocol and reset: with ready low, present 50 then change to 51 while valid is held.
  - Required: err_o = 1 and it stays 1 after flush.
  - Then assert rst_n = 0 mid-transfer: all outputs return to reset values immediately, including err_o = 0.
